// File: rtl/crc_generator.sv
// Byte-stream CRC-8 generator: passes message bytes through and appends one CRC byte.
// Optional CRC_XOROUT_EN inverts the appended CRC byte.
module crc_generator #(
   parameter logic [7:0] POLY = 8'h07,
   parameter logic [7:0] INIT = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   input  logic       s_last,
   output logic       s_ready,
   output logic [7:0] m_data,
   output logic       m_valid,
   output logic       m_last,
   input  logic       m_ready,
   output logic       busy,
   output logic       done
);

`ifdef CRC_XOROUT_EN
   localparam logic [7:0] XOROUT = 8'hFF;
`else
   localparam logic [7:0] XOROUT = 8'h00;
`endif

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      CRC,
      DONE
   } state_t;

   state_t     state_q;
   logic [7:0] crc_q;
   logic [7:0] crc_d;
   logic [7:0] m_data_q;
   logic       m_valid_q;
   logic       m_last_q;
   logic       done_q;
   logic       out_free;
   logic       accept;

   function automatic logic [7:0] crc8(
      input logic [7:0] c,
      input logic [7:0] d
   );
      logic [7:0] r;
      r = c ^ d;
      for (int i = 0; i < 8; i++) begin
         r = r[7] ? ({r[6:0], 1'b0} ^ POLY) : {r[6:0], 1'b0};
      end
      return r;
   endfunction

   // The output register is a one-entry buffer: it can be refilled in the
   // same cycle its current byte leaves.
   assign out_free = !m_valid_q || m_ready;
   assign s_ready  = (state_q == DATA) && out_free;
   assign accept   = s_valid && s_ready;
   assign crc_d    = crc8(crc_q, s_data);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         crc_q     <= INIT;
         m_data_q  <= 8'h00;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  crc_q   <= INIT;
                  state_q <= DATA;
               end
            end
            DATA: begin
               if (accept) begin
                  m_data_q  <= s_data;
                  m_valid_q <= 1'b1;
                  m_last_q  <= 1'b0;
                  crc_q     <= crc_d;
                  if (s_last) state_q <= CRC;
               end else if (m_valid_q && m_ready) begin
                  m_valid_q <= 1'b0;
               end
            end
            CRC: begin
               if (out_free) begin
                  m_data_q  <= crc_q ^ XOROUT;
                  m_valid_q <= 1'b1;
                  m_last_q  <= 1'b1;
                  state_q   <= DONE;
               end
            end
            DONE: begin
               if (m_ready) begin
                  m_valid_q <= 1'b0;
                  m_last_q  <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign m_data  = m_data_q;
   assign m_valid = m_valid_q;
   assign m_last  = m_last_q;
   assign done    = done_q;
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_crc_generator.sv
// Self-checking bench for crc_generator: vector table, hand sequences,
// and random frames with backpressure against a bit-serial CRC model.
module tb_crc_generator;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_last;
   logic       s_ready;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_last;
   logic       m_ready;
   logic       busy;
   logic       done;

`ifdef CRC_XOROUT_EN
   localparam logic [7:0] XO = 8'hFF;
`else
   localparam logic [7:0] XO = 8'h00;
`endif

   crc_generator dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .s_data  (s_data),
      .s_valid (s_valid),
      .s_last  (s_last),
      .s_ready (s_ready),
      .m_data  (m_data),
      .m_valid (m_valid),
      .m_last  (m_last),
      .m_ready (m_ready),
      .busy    (busy),
      .done    (done)
   );

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Bit-serial reference: message bits shifted through an LFSR MSB-first.
   function automatic logic [7:0] ref_crc(input logic [7:0] msg[$]);
      logic [7:0] c;
      logic       fb;
      c = 8'h00;
      foreach (msg[k]) begin
         for (int b = 7; b >= 0; b--) begin
            fb = c[7] ^ msg[k][b];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
         end
      end
      return c ^ XO;
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // 0: always ready, 1: random backpressure, 2: never ready
   int mode = 0;
   always @(posedge clk) begin
      #1;
      case (mode)
         1: m_ready = ($urandom_range(0, 99) < 55);
         2: m_ready = 1'b0;
         default: m_ready = 1'b1;
      endcase
   end

   logic [7:0] out_q[$];
   logic       last_q[$];
   int         done_cnt = 0;
   logic       stall_q = 1'b0;
   logic [7:0] hold_q = 8'h00;

   always @(negedge clk) begin
      if (!rst_n) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            check("hold_valid", int'(m_valid), 1);
            check("hold_data", int'(m_data), int'(hold_q));
         end
         if (m_valid && m_ready) begin
            out_q.push_back(m_data);
            last_q.push_back(m_last);
         end
         if (done) done_cnt++;
         stall_q = m_valid && !m_ready;
         hold_q  = m_data;
      end
   end

   task automatic send_frame(input logic [7:0] msg[$], input int start_idx);
      bit acc;
      int tmo;
      out_q.delete();
      last_q.delete();
      done_cnt = 0;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < msg.size(); i++) begin
         s_valid = 1'b1;
         s_data  = msg[i];
         s_last  = (i == msg.size() - 1);
         start   = (i == start_idx);
         acc = 1'b0;
         tmo = 0;
         while (!acc) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk); #1;
            start = 1'b0;
            tmo++;
            if (!acc && tmo > 300) begin
               check("accept_timeout", 0, 1);
               break;
            end
         end
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = 8'($urandom);
      tmo = 0;
      while (done_cnt == 0 && tmo < 300) begin
         @(negedge clk);
         tmo++;
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic check_frame(input string name, input logic [7:0] msg[$],
                              input logic [7:0] exp_crc);
      int bad;
      check({name, "_len"}, out_q.size(), msg.size() + 1);
      check({name, "_done"}, done_cnt, 1);
      if (out_q.size() == msg.size() + 1) begin
         bad = 0;
         foreach (msg[i]) begin
            if (out_q[i] !== msg[i] || last_q[i] !== 1'b0) bad++;
         end
         check({name, "_payload_errs"}, bad, 0);
         check({name, "_crc"}, int'(out_q[msg.size()]), int'(exp_crc));
         check({name, "_mlast"}, int'(last_q[msg.size()]), 1);
      end
   endtask

   typedef struct {
      int         len;
      logic [7:0] d[9];
      logic [7:0] exp;
   } vec_t;

   vec_t       vt[3];
   logic [7:0] msg[$];

   initial begin
      vt[0].len = 1;
      vt[0].d   = '{8'hAA, 0, 0, 0, 0, 0, 0, 0, 0};
      vt[1].len = 9;
      vt[1].d   = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                    8'h36, 8'h37, 8'h38, 8'h39};
      vt[2].len = 2;
      vt[2].d   = '{8'hAA, 8'h5F, 0, 0, 0, 0, 0, 0, 0};
`ifdef CRC_XOROUT_EN
      vt[0].exp = 8'hA0;
      vt[1].exp = 8'h0B;
      vt[2].exp = 8'hFF;
`else
      vt[0].exp = 8'h5F;
      vt[1].exp = 8'hF4;
      vt[2].exp = 8'h00;
`endif

      rst_n   = 1'b0;
      start   = 1'b0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = 8'h00;
      m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_mvalid", int'(m_valid), 0);
      check("rst_mlast", int'(m_last), 0);
      check("rst_mdata", int'(m_data), 0);
      check("rst_done", int'(done), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_sready", int'(s_ready), 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      foreach (vt[k]) begin
         msg.delete();
         for (int i = 0; i < vt[k].len; i++) msg.push_back(vt[k].d[i]);
         send_frame(msg, -1);
         check_frame($sformatf("vec%0d", k), msg, vt[k].exp);
      end

      // start with s_valid in IDLE, then single-byte latency walk
      @(posedge clk); #1;
      start = 1'b1; s_valid = 1'b1; s_data = 8'hAA; s_last = 1'b1;
      @(negedge clk);
      check("idle_sready", int'(s_ready), 0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("data_sready", int'(s_ready), 1);
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
      @(negedge clk);
      check("lat_data", int'(m_data), 'hAA);
      check("lat_valid", int'(m_valid), 1);
      check("lat_last0", int'(m_last), 0);
      check("lat_busy", int'(busy), 1);
      @(negedge clk);
      check("lat_crc", int'(m_data), int'(vt[0].exp));
      check("lat_last1", int'(m_last), 1);
      @(negedge clk);
      check("lat_done", int'(done), 1);
      check("lat_idle_valid", int'(m_valid), 0);
      check("lat_idle_busy", int'(busy), 0);
      @(negedge clk);
      check("lat_done_pulse", int'(done), 0);

      // start pulse in DATA ignored
      msg.delete();
      for (int i = 0; i < 6; i++) msg.push_back(8'($urandom));
      send_frame(msg, 3);
      check_frame("start_in_data", msg, ref_crc(msg));

      // random frames with backpressure
      mode = 1;
      for (int f = 0; f < 6; f++) begin
         msg.delete();
         for (int i = 0; i < ((f == 0) ? 16 : $urandom_range(1, 20)); i++)
            msg.push_back(8'($urandom));
         send_frame(msg, -1);
         check_frame($sformatf("rand%0d", f), msg, ref_crc(msg));
      end

      // reset mid-frame with output stalled
      mode = 2;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; s_valid = 1'b1; s_data = 8'h11;
      repeat (3) @(posedge clk);
      #1;
      check("mid_valid_pre", int'(m_valid), 1);
      done_cnt = 0;
      rst_n = 1'b0; s_valid = 1'b0;
      #1;
      check("mid_rst_valid", int'(m_valid), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_last", int'(m_last), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      mode = 0;
      repeat (2) @(posedge clk);
      check("mid_no_done", done_cnt, 0);
      msg.delete();
      for (int i = 0; i < 9; i++) msg.push_back(vt[1].d[i]);
      send_frame(msg, -1);
      check_frame("after_rst", msg, vt[1].exp);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
